udp_rx_payload_fifo: RTL and testbench
======================================

// Module: udp_rx_payload_fifo
// PURPOSE
//   Consumes the received byte stream of the 10BASE-T receiver (clkRx domain). Extracts the UDP
//   payload of each frame into a circular byte buffer, each payload preceded by a 2-byte length header.
//   Payloads are written speculatively. They become readable only when the frame ends with
//   rx_frame_ok; otherwise they are rolled back. A simple byte-read port feeds the USB readout logic.
// PARAMETERS
//   ADDR_W       9     buffer address width; DEPTH = 2**ADDR_W bytes
//   MAX_PAYLOAD  470   largest accepted UDP payload, in bytes; longer payloads are dropped
//   PAYLOAD_OFS  42    byte index of the first UDP payload byte (0 = first destination-MAC byte)
// PORTS
//   clkRx         in   1         receive clock, 24MHz; all logic on its rising edge
//   rstn          in   1         asynchronous active-low reset
//   rx_frame      in   1         high from the byte after SFD until end of frame
//   rx_byte_valid in   1         1-cycle strobe: rx_byte holds the next frame byte
//   rx_byte       in   8         received byte, LSB-first reassembled
//   rx_frame_end  in   1         1-cycle pulse; the frame is over
//   rx_frame_ok   in   1         sampled with rx_frame_end: CRC, MAC, IP and UDP checks passed
//   rd_en         in   1         read request; ignored when empty
//   rd_data       out  8         read byte, valid the cycle after an accepted rd_en
//   rd_valid      out  1         qualifies rd_data
//   empty         out  1         no committed bytes remain
//   fill          out  ADDR_W+1  committed bytes not yet read
//   pkt_count     out  16        payloads committed (wraps)
//   drop_count    out  16        frames dropped: bad, truncated, oversize or no space (wraps)
// BEHAVIOUR
//   Reset: all pointers = 0, state = IDLE, rd_valid = 0, rd_data = 0, empty = 1, fill = 0, counters = 0.
//   Reset mid-frame discards everything; the rest of that frame is ignored until rx_frame_end.
//   Pointers: wr_ptr (committed), spec_ptr (speculative), rd_ptr; each ADDR_W+1 bits, wrapping modulo 2*DEPTH.
//     fill = wr_ptr - rd_ptr; empty = (fill == 0); free = DEPTH - (spec_ptr - rd_ptr).
//   Byte index bidx: 11 bits; cleared while rx_frame = 0; +1 per rx_byte_valid; saturates at 2047.
//   FSM:
//     IDLE: first rx_byte_valid with rx_frame = 1 -> HDR.
//     HDR: latch udp_len[15:8] at bidx 38, udp_len[7:0] at bidx 39; plen = udp_len - 8 (16-bit).
//       At bidx 40: if udp_len < 8, plen > MAX_PAYLOAD, or plen + 2 > free -> DROP.
//       Otherwise write plen[15:8] at spec_ptr (bidx 40) and plen[7:0] (bidx 41); spec_ptr += 1 each.
//       If plen == 0 -> WAITEND, else -> PAYLOAD.
//     PAYLOAD: write each byte at spec_ptr; spec_ptr += 1; remaining -= 1; remaining == 0 -> WAITEND.
//       Trailing bytes (padding, CRC) are never written.
//     WAITEND: ignore bytes.
//       At rx_frame_end: rx_frame_ok = 1 -> wr_ptr <= spec_ptr, pkt_count += 1.
//       At rx_frame_end: rx_frame_ok = 0 -> spec_ptr <= wr_ptr, drop_count += 1. Then -> IDLE.
//     DROP: spec_ptr <= wr_ptr; ignore bytes; at rx_frame_end -> IDLE, drop_count += 1.
//   rx_frame_end in IDLE/HDR/PAYLOAD (runt or truncated frame): roll back, drop_count += 1, -> IDLE,
//     whatever rx_frame_ok says.
//   rx_frame_end has priority over a same-cycle rx_byte_valid; that byte is discarded.
//   Commit takes effect the cycle after rx_frame_end: fill, empty and readable data all update then.
//   Read: rd_en & ~empty -> RAM read at rd_ptr, rd_ptr += 1; rd_data and rd_valid = 1 on the next cycle.
//     Otherwise rd_valid = 0 and rd_data holds its value. Back-to-back reads sustain 1 byte/cycle.
//   Commit and read in the same cycle: fill = new wr_ptr - new rd_ptr, with no lost update.
//   Reads touch only committed space and writes only uncommitted space, so there is no address hazard.
//   Buffer: inferred simple dual-port RAM, synchronous write and read, 1-cycle read latency.
// TESTING
//   1) Good frame, udp_len = 26 (payload 00..11h): commit -> fill = 20 the cycle after end.
//      Reads return 00,12,00,01..11; pkt_count = 1; empty = 1 afterwards.
//   2) Same frame with rx_frame_ok = 0: fill stays 0, drop_count = 1, and the next good frame reads back cleanly.
//   3) Frame ends at bidx 30, inside the header: drop_count = 1, spec_ptr == wr_ptr, FSM back in IDLE.
//   4) ADDR_W = 6 (64 B), leave 40 B unread, send a 30-byte payload: dropped (32 > 24 free).
//      Read 20 B, resend: committed, and its pointers wrap correctly.
//   5) udp_len = 5 and udp_len = 8+471: both dropped. udp_len = 8: commits only the header 00,00.
//   6) Assert rstn = 0 mid-payload with fill = 10: fill = 0, empty = 1, rd_valid = 0.
//      Frame bytes before rx_frame_end are ignored; the next frame is accepted.

Source files
------------

// File: rtl/udp_rx_payload_fifo_if.sv
// ---------------------------------------------------------------------------
// udp_rx_payload_fifo_if
//   Bundles the receive byte stream and the byte-read port of the UDP payload
//   FIFO.
//   master : the side that drives the frame stream and read requests.
//   slave  : the FIFO itself.
// Signals
//   rx_frame, rx_byte_valid, rx_byte, rx_frame_end, rx_frame_ok : byte stream in
//   rd_en                                                        : read request
//   rd_data, rd_valid, empty, fill, pkt_count, drop_count        : FIFO status
// ---------------------------------------------------------------------------
interface udp_rx_payload_fifo_if #(
  parameter int ADDR_W = 9
);
  logic              rx_frame;
  logic              rx_byte_valid;
  logic [7:0]        rx_byte;
  logic              rx_frame_end;
  logic              rx_frame_ok;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              empty;
  logic [ADDR_W:0]   fill;
  logic [15:0]       pkt_count;
  logic [15:0]       drop_count;

  modport master (
    output rx_frame, rx_byte_valid, rx_byte, rx_frame_end, rx_frame_ok, rd_en,
    input  rd_data, rd_valid, empty, fill, pkt_count, drop_count
  );

  modport slave (
    input  rx_frame, rx_byte_valid, rx_byte, rx_frame_end, rx_frame_ok, rd_en,
    output rd_data, rd_valid, empty, fill, pkt_count, drop_count
  );
endinterface

// File: rtl/udp_rx_payload_fifo.sv
// ---------------------------------------------------------------------------
// udp_rx_payload_fifo
//   Extracts the UDP payload of each received Ethernet frame into a circular
//   byte buffer, each payload preceded by a 2-byte big-endian length header.
//   Bytes are written speculatively and only become readable once the frame
//   ends with rx_frame_ok; bad, truncated, oversize or no-space frames are
//   rolled back. A 1-cycle-latency byte read port drains committed data.
// Ports
//   clkRx : receive clock, all logic on its rising edge
//   rstn  : asynchronous active-low reset
//   bus   : slave side of udp_rx_payload_fifo_if (stream in, read port out)
// ---------------------------------------------------------------------------
module udp_rx_payload_fifo #(
  parameter int ADDR_W      = 9,
  parameter int MAX_PAYLOAD = 470,
  parameter int PAYLOAD_OFS = 42
) (
  input  logic                   clkRx,
  input  logic                   rstn,
  udp_rx_payload_fifo_if.slave   bus
);

  localparam int                DEPTH       = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_V     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [15:0]       MAX_P       = 16'(MAX_PAYLOAD);
  localparam logic [10:0]       IDX_LEN_HI  = 11'(PAYLOAD_OFS - 4);
  localparam logic [10:0]       IDX_LEN_LO  = 11'(PAYLOAD_OFS - 3);
  localparam logic [10:0]       IDX_PLEN_HI = 11'(PAYLOAD_OFS - 2);
  localparam logic [10:0]       IDX_PLEN_LO = 11'(PAYLOAD_OFS - 1);
  localparam logic [10:0]       BIDX_MAX    = 11'd2047;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_WAITEND = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  logic [7:0]       mem [DEPTH];

  state_t           state_r;
  logic [10:0]      bidx_r;
  logic [15:0]      udp_len_r;
  logic [15:0]      remaining_r;
  logic [ADDR_W:0]  wr_ptr_r;
  logic [ADDR_W:0]  spec_ptr_r;
  logic [ADDR_W:0]  rd_ptr_r;
  logic [ADDR_W:0]  fill_r;
  logic             empty_r;
  logic [7:0]       rd_data_r;
  logic             rd_valid_r;
  logic [15:0]      pkt_count_r;
  logic [15:0]      drop_count_r;
  // Set by reset: a frame may already be in flight, so everything up to the
  // next rx_frame_end (or an idle line) must be ignored.
  logic             skip_r;

  logic             byte_s;
  logic [15:0]      plen_s;
  logic [ADDR_W:0]  free_s;
  logic [16:0]      need_s;
  logic             hdr_drop_s;
  logic             we_s;
  logic [7:0]       wdata_s;
  logic             commit_s;
  logic             rd_acc_s;
  logic [ADDR_W:0]  wr_ptr_nxt_s;
  logic [ADDR_W:0]  rd_ptr_nxt_s;

  // A frame end wins over a same-cycle byte, which is then discarded.
  assign byte_s       = bus.rx_byte_valid & bus.rx_frame & ~bus.rx_frame_end;
  assign plen_s       = udp_len_r - 16'd8;
  assign free_s       = DEPTH_V - (spec_ptr_r - rd_ptr_r);
  assign need_s       = {1'b0, plen_s} + 17'd2;
  assign hdr_drop_s   = (udp_len_r < 16'd8) | (plen_s > MAX_P) | (need_s > 17'(free_s));
  assign commit_s     = bus.rx_frame_end & bus.rx_frame_ok & ~skip_r & (state_r == ST_WAITEND);
  assign rd_acc_s     = bus.rd_en & ~empty_r;
  assign wr_ptr_nxt_s = commit_s ? spec_ptr_r : wr_ptr_r;
  assign rd_ptr_nxt_s = rd_acc_s ? (rd_ptr_r + {{ADDR_W{1'b0}}, 1'b1}) : rd_ptr_r;

  // Buffer write enable and data: length header in HDR, payload in PAYLOAD.
  always_comb begin
    we_s    = 1'b0;
    wdata_s = 8'h00;
    case (state_r)
      ST_HDR: begin
        if (byte_s && (bidx_r == IDX_PLEN_HI) && !hdr_drop_s) begin
          we_s    = 1'b1;
          wdata_s = plen_s[15:8];
        end else if (byte_s && (bidx_r == IDX_PLEN_LO)) begin
          we_s    = 1'b1;
          wdata_s = plen_s[7:0];
        end else begin
          we_s    = 1'b0;
          wdata_s = 8'h00;
        end
      end
      ST_PAYLOAD: begin
        if (byte_s) begin
          we_s    = 1'b1;
          wdata_s = bus.rx_byte;
        end else begin
          we_s    = 1'b0;
          wdata_s = 8'h00;
        end
      end
      default: begin
        we_s    = 1'b0;
        wdata_s = 8'h00;
      end
    endcase
  end

  // Buffer write port (no reset: plain inferred RAM).
  always_ff @(posedge clkRx) begin
    if (we_s) begin
      mem[spec_ptr_r[ADDR_W-1:0]] <= wdata_s;
    end
  end

  // Read port, committed/read pointers and registered fill/empty.
  always_ff @(posedge clkRx or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fill_r     <= '0;
      empty_r    <= 1'b1;
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
    end else begin
      if (rd_acc_s) begin
        rd_data_r  <= mem[rd_ptr_r[ADDR_W-1:0]];
        rd_valid_r <= 1'b1;
      end else begin
        rd_valid_r <= 1'b0;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      // Computed from the next pointers so a commit and a read in the same
      // cycle both land in fill.
      fill_r   <= wr_ptr_nxt_s - rd_ptr_nxt_s;
      empty_r  <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
    end
  end

  // Frame parser FSM: byte index, speculative pointer and frame counters.
  always_ff @(posedge clkRx or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      bidx_r       <= 11'd0;
      udp_len_r    <= 16'd0;
      remaining_r  <= 16'd0;
      spec_ptr_r   <= '0;
      pkt_count_r  <= 16'd0;
      drop_count_r <= 16'd0;
      skip_r       <= 1'b1;
    end else begin
      if (!bus.rx_frame) begin
        bidx_r <= 11'd0;
      end else if (bus.rx_byte_valid && (bidx_r != BIDX_MAX)) begin
        bidx_r <= bidx_r + 11'd1;
      end else begin
        bidx_r <= bidx_r;
      end

      if (we_s) begin
        spec_ptr_r <= spec_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
      end

      if (bus.rx_frame_end) begin
        skip_r  <= 1'b0;
        state_r <= ST_IDLE;
        if (!skip_r) begin
          if (commit_s) begin
            pkt_count_r <= pkt_count_r + 16'd1;
          end else begin
            spec_ptr_r   <= wr_ptr_r;
            drop_count_r <= drop_count_r + 16'd1;
          end
        end
      end else begin
        if (!bus.rx_frame) begin
          skip_r <= 1'b0;
        end
        case (state_r)
          ST_IDLE: begin
            if (byte_s && !skip_r) begin
              state_r <= ST_HDR;
            end
          end
          ST_HDR: begin
            if (byte_s) begin
              if (bidx_r == IDX_LEN_HI) begin
                udp_len_r[15:8] <= bus.rx_byte;
              end else if (bidx_r == IDX_LEN_LO) begin
                udp_len_r[7:0] <= bus.rx_byte;
              end else if (bidx_r == IDX_PLEN_HI) begin
                if (hdr_drop_s) begin
                  state_r <= ST_DROP;
                end
              end else if (bidx_r == IDX_PLEN_LO) begin
                remaining_r <= plen_s;
                state_r     <= (plen_s == 16'd0) ? ST_WAITEND : ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (byte_s) begin
              remaining_r <= remaining_r - 16'd1;
              if (remaining_r == 16'd1) begin
                state_r <= ST_WAITEND;
              end
            end
          end
          ST_WAITEND: begin
            state_r <= ST_WAITEND;
          end
          ST_DROP: begin
            spec_ptr_r <= wr_ptr_r;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rd_data    = rd_data_r;
  assign bus.rd_valid   = rd_valid_r;
  assign bus.empty      = empty_r;
  assign bus.fill       = fill_r;
  assign bus.pkt_count  = pkt_count_r;
  assign bus.drop_count = drop_count_r;

endmodule

// File: tb/tb_udp_rx_payload_fifo.sv
// ---------------------------------------------------------------------------
// tb_udp_rx_payload_fifo
//   Directed bench for udp_rx_payload_fifo. A 512-byte instance runs a table
//   of frames; a 64-byte instance covers the no-space and wrap case. Inputs
//   are driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_udp_rx_payload_fifo;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        sel6;
  logic        drv_frame, drv_valid, drv_end, drv_ok, drv_rd;
  logic [7:0]  drv_byte;

  udp_rx_payload_fifo_if #(.ADDR_W(9)) bus9 ();
  udp_rx_payload_fifo_if #(.ADDR_W(6)) bus6 ();

  assign bus9.rx_frame      = drv_frame & ~sel6;
  assign bus9.rx_byte_valid = drv_valid & ~sel6;
  assign bus9.rx_byte       = drv_byte;
  assign bus9.rx_frame_end  = drv_end & ~sel6;
  assign bus9.rx_frame_ok   = drv_ok;
  assign bus9.rd_en         = drv_rd & ~sel6;
  assign bus6.rx_frame      = drv_frame & sel6;
  assign bus6.rx_byte_valid = drv_valid & sel6;
  assign bus6.rx_byte       = drv_byte;
  assign bus6.rx_frame_end  = drv_end & sel6;
  assign bus6.rx_frame_ok   = drv_ok;
  assign bus6.rd_en         = drv_rd & sel6;

  udp_rx_payload_fifo #(.ADDR_W(9), .MAX_PAYLOAD(470), .PAYLOAD_OFS(42)) dut9 (
    .clkRx (clk), .rstn (rstn), .bus (bus9)
  );
  udp_rx_payload_fifo #(.ADDR_W(6), .MAX_PAYLOAD(470), .PAYLOAD_OFS(42)) dut6 (
    .clkRx (clk), .rstn (rstn), .bus (bus6)
  );

  logic [9:0]  mon_fill;
  logic [7:0]  mon_data;
  logic        mon_valid, mon_empty;
  logic [15:0] mon_pkt, mon_drop;
  assign mon_fill  = sel6 ? {3'b000, bus6.fill} : bus9.fill;
  assign mon_data  = sel6 ? bus6.rd_data : bus9.rd_data;
  assign mon_valid = sel6 ? bus6.rd_valid : bus9.rd_valid;
  assign mon_empty = sel6 ? bus6.empty : bus9.empty;
  assign mon_pkt   = sel6 ? bus6.pkt_count : bus9.pkt_count;
  assign mon_drop  = sel6 ? bus6.drop_count : bus9.drop_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [15:0] ulen;
    bit          ok;
    int          trunc;
    logic [7:0]  pbase;
    bit          commit;
    int          fill;
    int          pkt;
    int          drop;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int i, input logic [15:0] ulen,
                                            input logic [7:0] pbase, input int pl);
    if (i < 38)           return 8'(i * 7 + 3);
    else if (i == 38)     return ulen[15:8];
    else if (i == 39)     return ulen[7:0];
    else if (i == 40)     return 8'hC3;
    else if (i == 41)     return 8'h5E;
    else if (i < 42 + pl) return 8'(i - 42) + pbase;
    else                  return 8'hEE;
  endfunction

  // Sends one frame; trunc > 0 ends it early at that byte index, rst_at >= 0
  // pulses reset at that byte, rd_at_end issues a read in the end cycle.
  task automatic send_frame(input logic [15:0] ulen, input bit ok, input int trunc,
                            input int rst_at, input logic [7:0] pbase,
                            input bit commit, input bit rd_at_end);
    int pl;
    int n;
    logic [7:0] e;
    pl = (ulen >= 16'd8) ? int'(ulen) - 8 : 0;
    n  = 42 + pl;
    if (n < 60) n = 60;
    n += 4;
    for (int i = 0; i < n; i++) begin
      if (trunc > 0 && i == trunc) break;
      @(negedge clk);
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("rst_fill", int'(mon_fill), 0);
        chk("rst_empty", int'(mon_empty), 1);
        chk("rst_rd_valid", int'(mon_valid), 0);
        rstn = 1'b1;
      end
      if (rst_at >= 0 && i == rst_at) begin
        rstn = 1'b0;
        exp_q.delete();
      end
      drv_frame = 1'b1;
      drv_valid = 1'b1;
      drv_byte  = frame_byte(i, ulen, pbase, pl);
    end
    @(negedge clk);
    drv_valid = 1'b1;
    drv_byte  = 8'hEE;
    drv_end   = 1'b1;
    drv_ok    = ok;
    drv_rd    = rd_at_end;
    @(negedge clk);
    drv_frame = 1'b0;
    drv_valid = 1'b0;
    drv_end   = 1'b0;
    drv_ok    = 1'b0;
    drv_rd    = 1'b0;
    if (rd_at_end) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      chk("end_rd_valid", int'(mon_valid), 1);
      chk("end_rd_data", int'(mon_data), int'(e));
    end
    if (commit) begin
      exp_q.push_back(8'(pl >> 8));
      exp_q.push_back(8'(pl));
      for (int k = 0; k < pl; k++) exp_q.push_back(8'(k) + pbase);
    end
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("rd_valid", int'(mon_valid), 1);
        if (exp_q.size() == 0) begin
          chk("rd_model_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", int'(mon_data), int'(e));
        end
      end
      drv_rd = (i < n);
    end
    chk("drain_empty", int'(mon_empty), 1);
    chk("drain_fill", int'(mon_fill), 0);
  endtask

  task automatic status(input string tag, input int fill, input int pkt, input int drop);
    chk({tag, "_fill"}, int'(mon_fill), fill);
    chk({tag, "_empty"}, int'(mon_empty), (fill == 0) ? 1 : 0);
    chk({tag, "_pkt"}, int'(mon_pkt), pkt);
    chk({tag, "_drop"}, int'(mon_drop), drop);
  endtask

  initial begin
    //            ulen     ok    trunc pbase  commit fill pkt drop
    vecs[0] = '{16'd26,  1'b1, 0,  8'h00, 1'b1, 20,  1, 0};
    vecs[1] = '{16'd26,  1'b0, 0,  8'h40, 1'b0, 0,   1, 1};
    vecs[2] = '{16'd26,  1'b1, 0,  8'h80, 1'b1, 20,  2, 1};
    vecs[3] = '{16'd26,  1'b1, 30, 8'h00, 1'b0, 0,   2, 2};
    vecs[4] = '{16'd5,   1'b1, 0,  8'h00, 1'b0, 0,   2, 3};
    vecs[5] = '{16'd479, 1'b1, 0,  8'h10, 1'b0, 0,   2, 4};
    vecs[6] = '{16'd8,   1'b1, 0,  8'h00, 1'b1, 2,   3, 4};
    vecs[7] = '{16'd478, 1'b1, 0,  8'h20, 1'b1, 472, 4, 4};
    vecs[8] = '{16'd100, 1'b1, 50, 8'h00, 1'b0, 0,   4, 5};
    vecs[9] = '{16'd60,  1'b1, 0,  8'h33, 1'b1, 54,  5, 5};

    sel6 = 1'b0;
    drv_frame = 1'b0; drv_valid = 1'b0; drv_end = 1'b0; drv_ok = 1'b0; drv_rd = 1'b0;
    drv_byte = 8'h00;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    status("reset", 0, 0, 0);
    chk("reset_rd_valid", int'(mon_valid), 0);
    chk("reset_rd_data", int'(mon_data), 0);

    // Table of frames on the 512-byte instance, each drained afterwards.
    for (int v = 0; v < 10; v++) begin
      send_frame(vecs[v].ulen, vecs[v].ok, vecs[v].trunc, -1, vecs[v].pbase,
                 vecs[v].commit, 1'b0);
      status($sformatf("vec%0d", v), vecs[v].fill, vecs[v].pkt, vecs[v].drop);
      drain(vecs[v].fill);
    end

    // 64-byte instance: no space for 32 B with 24 free, then fits after reads.
    sel6 = 1'b1;
    @(negedge clk);
    send_frame(16'd46, 1'b1, 0, -1, 8'h60, 1'b1, 1'b0);
    status("small_a", 40, 1, 0);
    send_frame(16'd38, 1'b1, 0, -1, 8'h70, 1'b0, 1'b0);
    status("small_nospace", 40, 1, 1);
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i > 0) chk("small_rd_data", int'(mon_data), int'(exp_q.pop_front()));
      drv_rd = (i < 20);
    end
    chk("small_part_fill", int'(mon_fill), 20);
    send_frame(16'd38, 1'b1, 0, -1, 8'h90, 1'b1, 1'b0);
    status("small_wrap", 52, 2, 1);
    drain(52);
    sel6 = 1'b0;
    @(negedge clk);

    // Commit and read in the same cycle.
    send_frame(16'd26, 1'b1, 0, -1, 8'h05, 1'b1, 1'b0);
    chk("cr_fill_a", int'(mon_fill), 20);
    send_frame(16'd26, 1'b1, 0, -1, 8'h15, 1'b1, 1'b1);
    chk("cr_fill_b", int'(mon_fill), 39);
    chk("cr_pkt", int'(mon_pkt), 7);
    drain(39);

    // Read while empty is ignored and rd_data holds the last byte (0x15+17).
    @(negedge clk);
    drv_rd = 1'b1;
    @(negedge clk);
    drv_rd = 1'b0;
    chk("empty_rd_valid", int'(mon_valid), 0);
    chk("empty_rd_hold", int'(mon_data), 8'h26);
    chk("empty_rd_fill", int'(mon_fill), 0);

    // Reset in the middle of a payload with 10 committed bytes.
    send_frame(16'd16, 1'b1, 0, -1, 8'h70, 1'b1, 1'b0);
    chk("pre_rst_fill", int'(mon_fill), 10);
    send_frame(16'd26, 1'b1, 0, 45, 8'h50, 1'b0, 1'b0);
    chk("post_rst_fill", int'(mon_fill), 0);
    chk("post_rst_empty", int'(mon_empty), 1);
    chk("post_rst_pkt", int'(mon_pkt), 0);
    send_frame(16'd26, 1'b1, 0, -1, 8'hA0, 1'b1, 1'b0);
    chk("after_rst_fill", int'(mon_fill), 20);
    chk("after_rst_pkt", int'(mon_pkt), 1);
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
